uart_frame_rx: RTL and testbench

Framing stage sitting directly downstream of `uart_rx`. Consumes the received byte stream over the same valid/ready handshake `uart_rx` presents and extracts length-prefixed, checksummed frames. Buffers each payload until the checksum is verified, then releases it as a packet stream with a last marker. Malformed frames are dropped and reported on an error pulse with a code.

---
 rtl/uart_frame_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx
//   Framing stage behind uart_rx. Parses SOF, LEN, LEN payload bytes, CSUM
//   from the byte stream. The payload is held in a local buffer until the
//   checksum is verified, then released as a packet stream with a last marker.
//   Malformed frames are dropped and reported with an error pulse and a code.
//
//   Optional feature: define UART_FRAME_TIMEOUT_EN to abort a frame whose
//   next byte does not arrive within TIMEOUT_CYCLES clocks (err_code 3).
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   in_data/in_valid    byte stream from uart_rx
//   in_ready            byte accepted on in_valid && in_ready (low while draining)
//   out_data/out_valid  verified payload bytes
//   out_ready           downstream accept
//   out_last            final payload byte of the frame (qualified by out_valid)
//   frame_ok            one-cycle pulse, checksum matched
//   frame_err           one-cycle pulse, frame dropped
//   err_code            1 checksum, 2 length, 3 timeout; held until next error
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | hunting for SOF, other bytes discarded
// S_LEN     | next byte is the payload length
// S_PAYLOAD | storing payload bytes into buf_mem, accumulating sum
// S_CSUM    | next byte is compared against the accumulated sum
// S_DRAIN   | presenting buffered payload downstream, input stalled
module uart_frame_rx #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MAX_LEN        = 16,
  parameter logic [DATA_WIDTH-1:0] SOF            = 8'h7E,
  parameter int                    TIMEOUT_CYCLES = 8680
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int DEPTH = 1 << CW;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > (1 << DATA_WIDTH) - 1 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("uart_frame_rx: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_DRAIN
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          len, idx, rd;
  logic [DATA_WIDTH-1:0]  sum;
  logic [DATA_WIDTH-1:0]  buf_mem [DEPTH];
  logic                   accept, emit, len_ok, timeout_hit;
  logic                   ok_nxt, err_nxt;
  logic [1:0]             code_nxt;

  // Handshake signals decode only registered state: no in_valid -> in_ready path.
  assign in_ready  = (state != S_DRAIN);
  assign out_valid = (state == S_DRAIN);
  assign out_data  = out_valid ? buf_mem[rd] : '0;
  assign out_last  = out_valid && (rd == len - CW'(1));
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;
  assign len_ok    = (in_data != '0) && (in_data <= MAX_LEN_B);

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          waiting;

  assign waiting     = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  // Fires on the TIMEOUT_CYCLES-th idle clock since the last accepted byte.
  assign timeout_hit = waiting && !accept && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!waiting || accept || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    unique case (state)
      S_IDLE: begin
        if (accept && in_data == SOF) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (len_ok) begin
            state_nxt = S_PAYLOAD;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            code_nxt  = 2'd2;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept && idx == len - CW'(1)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == sum) begin
            state_nxt = S_DRAIN;
            ok_nxt    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
            code_nxt  = 2'd1;
          end
        end
      end
      S_DRAIN: begin
        if (emit && out_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout_hit) begin
      state_nxt = S_IDLE;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b1;
      code_nxt  = 2'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
      len       <= '0;
      idx       <= '0;
      rd        <= '0;
      sum       <= '0;
    end else begin
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
      if (state == S_LEN && accept && len_ok) begin
        len <= in_data[CW-1:0];
        sum <= in_data;
        idx <= '0;
      end
      if (state == S_PAYLOAD && accept) begin
        sum <= sum + in_data;
        idx <= idx + CW'(1);
      end
      if (emit) begin
        rd <= out_last ? '0 : rd + CW'(1);
      end
    end
  end

  // Payload storage carries no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (state == S_PAYLOAD && accept) begin
      buf_mem[idx] <= in_data;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
module tb_uart_frame_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic       frame_ok, frame_err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;

  // Frame-level model: expected events (0 ok, else error code) and bytes {last,data}.
  int         exp_ev[$];
  logic [8:0] exp_out[$];
  logic [8:0] cap[$];
  int         exp_code = 0;
  int         vcnt = 0;
  int         stall_cnt = 0;
  bit         rnd_rdy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out = 9'h0;

  uart_frame_rx dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0] p[$]);
    logic [7:0] s;
    s = 8'(p.size());
    foreach (p[i]) s = s + p[i];
    return s;
  endfunction

  task automatic expect_good(input logic [7:0] p[$]);
    exp_ev.push_back(0);
    foreach (p[i]) exp_out.push_back({(i == p.size() - 1), p[i]});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      done = in_ready;
      @(posedge clk);
      @(negedge clk);
    end
    if (!done) chk("byte_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] q[$]);
    foreach (q[i]) begin
      if (rnd_rdy && $urandom_range(0, 3) == 0) @(negedge clk);
      send_byte(q[i]);
    end
  endtask

  task automatic send_good(input logic [7:0] p[$]);
    logic [7:0] q[$];
    expect_good(p);
    q = {8'h7E, 8'(p.size())};
    foreach (p[i]) q.push_back(p[i]);
    q.push_back(csum(p));
    send_list(q);
  endtask

  task automatic settle();
    for (int i = 0; i < 4000 && (exp_ev.size() != 0 || exp_out.size() != 0); i++)
      @(negedge clk);
    chk("expectations_drained", exp_ev.size() + exp_out.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Single compare process; also owns out_ready so the handshake it scores
  // is exactly the one the DUT sees at the next posedge.
  always begin : cmp
    int ev;
    @(negedge clk);
    #1;
    if (stall_cnt > 0 && out_valid) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (rnd_rdy) begin
      out_ready = ($urandom_range(0, 9) < 7);
    end else begin
      out_ready = 1'b1;
    end
    if (rst) begin
      chk("reset_outputs",
          int'({in_ready, out_valid, out_last, frame_ok, frame_err, err_code, out_data}),
          32'h4000);
      exp_code   = 0;
      prev_stall = 1'b0;
    end else begin
      if (frame_ok || frame_err) begin
        chk("ok_err_exclusive", int'(frame_ok && frame_err), 0);
        if (exp_ev.size() == 0) begin
          chk("event_expected", 0, 1);
        end else begin
          ev = exp_ev.pop_front();
          chk("event_kind", frame_ok ? 0 : int'(err_code), ev);
          chk("out_valid_with_event", int'(out_valid), (ev == 0) ? 1 : 0);
          if (ev != 0) exp_code = ev;
        end
      end
      chk("err_code_hold", int'(err_code), exp_code);
      if (out_valid) begin
        vcnt++;
        chk("in_ready_low_in_drain", int'(in_ready), 0);
        if (prev_stall) chk("stall_stable", int'({out_last, out_data}), int'(prev_out));
        if (out_ready) begin
          if (exp_out.size() == 0) chk("out_byte_expected", 0, 1);
          else chk("out_byte", int'({out_last, out_data}), int'(exp_out.pop_front()));
          cap.push_back({out_last, out_data});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_last, out_data};
    end
  end

  initial begin : main
    logic [7:0] q[$];
    logic [7:0] p[$];
    int         kind;
    int         len_r;
    logic [7:0] g;

    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_err_code", int'(err_code), 0);
    rst = 1'b0;
    @(negedge clk);

    // good frame, out_ready held high
    cap.delete(); vcnt = 0;
    p = {8'h11, 8'h22, 8'h33};
    expect_good(p);
    q = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_list(q);
    settle();
    chk("good_count", cap.size(), 3);
    chk("good_b0", int'(cap[0]), 32'h011);
    chk("good_b1", int'(cap[1]), 32'h022);
    chk("good_b2", int'(cap[2]), 32'h133);
    chk("good_valid_cycles", vcnt, 3);

    // bad checksum
    cap.delete();
    exp_ev.push_back(1);
    q = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    send_list(q);
    settle();
    chk("csum_err_code", int'(err_code), 1);
    chk("csum_no_output", cap.size(), 0);

    // length limits
    exp_ev.push_back(2);
    q = {8'h7E, 8'h00};
    send_list(q);
    settle();
    chk("len0_err_code", int'(err_code), 2);
    exp_ev.push_back(2);
    q = {8'h7E, 8'h11};
    send_list(q);
    settle();
    chk("len17_err_code", int'(err_code), 2);
    cap.delete();
    p.delete();
    repeat (16) p.push_back(8'($urandom_range(0, 255)));
    send_good(p);
    settle();
    chk("maxlen_count", cap.size(), 16);
    chk("maxlen_last", int'(cap[15][8]), 1);
    chk("maxlen_first_not_last", int'(cap[0][8]), 0);

    // backpressure at first out_valid
    cap.delete();
    stall_cnt = 5;
    p = {8'h11, 8'h22, 8'h33};
    expect_good(p);
    q = {8'h7E, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_list(q);
    settle();
    chk("bp_stall_used", stall_cnt, 0);
    chk("bp_count", cap.size(), 3);
    chk("bp_b0", int'(cap[0]), 32'h011);
    chk("bp_b2", int'(cap[2]), 32'h133);

    // garbage before a frame
    cap.delete();
    p = {8'hAA};
    expect_good(p);
    q = {8'h00, 8'hFF, 8'h7E, 8'h01, 8'hAA, 8'hAB};
    send_list(q);
    settle();
    chk("garbage_count", cap.size(), 1);
    chk("garbage_b0", int'(cap[0]), 32'h1AA);

    // reset mid-frame
    q = {8'h7E, 8'h02, 8'h11};
    send_list(q);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_rst_err", int'(frame_err), 0);
    rst = 1'b0;
    @(negedge clk);
    p = {8'h5A};
    send_good(p);
    settle();
    chk("after_rst_err_code", int'(err_code), 0);

    // reset mid-drain
    stall_cnt = 3;
    p = {8'h01, 8'h02};
    send_good(p);
    for (int i = 0; i < 200 && exp_ev.size() != 0; i++) @(negedge clk);
    rst = 1'b1;
    exp_out.delete();
    repeat (2) @(negedge clk);
    chk("middrain_rst_valid", int'(out_valid), 0);
    rst = 1'b0;
    stall_cnt = 0;
    @(negedge clk);

    // stalled frame: timeout with the macro, indefinite wait without
`ifdef UART_FRAME_TIMEOUT_EN
    exp_ev.push_back(3);
`endif
    q = {8'h7E, 8'h02, 8'h11};
    send_list(q);
    repeat (9000) @(negedge clk);
    chk("stall_in_ready", int'(in_ready), 1);
    chk("stall_no_output", int'(out_valid), 0);
`ifdef UART_FRAME_TIMEOUT_EN
    chk("stall_err_code", int'(err_code), 3);
`else
    chk("stall_err_code", int'(err_code), 0);
    p = {8'h11, 8'h22};
    expect_good(p);
`endif
    q = {8'h22, 8'h35};
    send_list(q);
    settle();

    // randomized frames against the frame-level model
    rnd_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      p.delete();
      q.delete();
      if (kind <= 4) begin
        len_r = $urandom_range(1, 16);
        repeat (len_r) p.push_back(8'($urandom_range(0, 255)));
        send_good(p);
      end else if (kind <= 6) begin
        len_r = $urandom_range(1, 16);
        repeat (len_r) p.push_back(8'($urandom_range(0, 255)));
        exp_ev.push_back(1);
        q = {8'h7E, 8'(len_r)};
        foreach (p[i]) q.push_back(p[i]);
        q.push_back(csum(p) ^ 8'($urandom_range(1, 255)));
        send_list(q);
      end else if (kind == 7) begin
        exp_ev.push_back(2);
        if ($urandom_range(0, 1) == 0) g = 8'h00;
        else g = 8'($urandom_range(17, 255));
        q = {8'h7E, g};
        send_list(q);
      end else begin
        repeat ($urandom_range(1, 3)) begin
          g = 8'($urandom_range(0, 255));
          if (g == 8'h7E) g = 8'h7F;
          q.push_back(g);
        end
        send_list(q);
      end
    end
    settle();
    rnd_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
